read_superpixel: RTL
====================

// Module: read_superpixel
// PURPOSE
//  Reader counterpart of the superpixel writer: given a superpixel (x,y) on the 64x48 grid, reads the
//  colour ID back from the 640x480 VGA frame RAM through its read port and returns it with a done strobe.
//  Used by game logic (collision / food checks) to sample the board without a shadow copy of the frame.
//  Sits between game control and the VGA RAM read port; owns no RAM itself.
// PARAMETERS
//  SPIXEL_X_WIDTH  6    superpixel x width
//  SPIXEL_Y_WIDTH  6    superpixel y width
//  SPX_W           10   pixels per superpixel horizontally (640/64)
//  SPX_H           10   pixels per superpixel vertically (480/48)
//  H_RES           640  pixels per frame line; addr = py*H_RES + px
//  VGA_ADDR_WIDTH  19   frame RAM address width
//  COLOR_ID_WIDTH  8    colour ID width
//  RD_LATENCY      2    RAM read latency in cycles (address cycle -> data cycle), >=1
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-high
//  x          in   6   superpixel column 0..63, sampled with ireq
//  y          in   6   superpixel row 0..47, sampled with ireq
//  ireq       in   1   read request, one-cycle pulse; honoured only when obusy=0
//  obusy      out  1   high from cycle after accepted ireq until cycle after odone
//  oaddr      out  19  RAM read address
//  ordreq     out  1   RAM read enable, qualifies oaddr
//  idata      in   8   RAM read data, valid RD_LATENCY cycles after its address cycle
//  odata      out  8   colour ID read back; held until next accepted request
//  odone      out  1   one-cycle pulse: odata (and omismatch) valid
//  omismatch  out  1   VERIFY build only: superpixel not uniform colour
// BEHAVIOUR
//  - Reset: obusy=0, ordreq=0, oaddr=0, odata=0, odone=0, omismatch=0, FSM=IDLE, in-flight tags cleared.
//  - Mapping: tlx=x*SPX_W, tly=y*SPX_H; brx=tlx+SPX_W-1, bry=tly+SPX_H-1; x,y assumed in range.
//  - FSM IDLE -> ISSUE on ireq (x,y latched); ISSUE -> DRAIN after last address; DRAIN -> IDLE when
//    last tagged datum returns (odone pulses on that transition).
//  - ireq while obusy=1 is ignored (no queueing); ireq in same cycle as odone also ignored.
//  - ISSUE: one address per cycle, ordreq=1; ordreq=0 in IDLE/DRAIN.
//  - Return tracking: RD_LATENCY-deep valid shift register fed by ordreq; a 'last' tag rides with the final address.
//  - idata captured into odata on the cycle its tag emerges; odone registered one cycle later.
//  - Latency (base build): ireq cycle 0 -> ordreq cycle 1 -> odone cycle 2+RD_LATENCY (=4 default).
//  - Reset mid-operation: FSM to IDLE immediately, tags flushed, no odone for aborted request.
//  - Address arithmetic at full VGA_ADDR_WIDTH; max address 307199 fits 19 bits, no wrap.
// CONFIGURATION
//  READ_SPIXEL_VERIFY_EN undefined: ISSUE emits only top-left pixel (1 address); omismatch tied 0.
//  READ_SPIXEL_VERIFY_EN defined: ISSUE raster-scans all SPX_W*SPX_H pixels, x fastest, wrap px brx->tlx
//    with py+1, last at (brx,bry); odata = top-left pixel colour; omismatch=1 if any returned pixel differs
//    from first; cleared on accept. Latency: odone at cycle 1+SPX_W*SPX_H+RD_LATENCY (=103 default).
// TESTING
//  1 ireq x=0,y=0, RAM[0]=8'h1C -> ordreq cycle 1 oaddr=0; odone cycle 4; odata=8'h1C.
//  2 ireq x=63,y=47 -> oaddr=301430 (470*640+630); odone cycle 4 with RAM[301430].
//  3 second ireq at cycles 1..3 of busy read -> ignored: one odone, one ordreq pulse, odata from first.
//  4 rst at cycle 2 of read -> obusy=0 next cycle, no odone; fresh ireq afterwards completes normally.
//  5 VERIFY, x=63,y=47, all 100 pixels 8'h05 -> addrs 301430..307199, 100 ordreq cycles, odone cycle 103, omismatch=0.
//  6 VERIFY, x=1,y=1, RAM[(19*640)+19]=8'hFF, rest 8'h05 -> odata=8'h05, omismatch=1.

Source files
------------

// File: rtl/read_superpixel.sv
// Reads a superpixel's colour ID back from the VGA frame RAM read port, returning it with a done strobe.
// Optional build macro READ_SPIXEL_VERIFY_EN scans every pixel of the superpixel and flags non-uniform colour.
module read_superpixel #(
  parameter int SPIXEL_X_WIDTH = 6,
  parameter int SPIXEL_Y_WIDTH = 6,
  parameter int SPX_W          = 10,
  parameter int SPX_H          = 10,
  parameter int H_RES          = 640,
  parameter int VGA_ADDR_WIDTH = 19,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int RD_LATENCY     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SPIXEL_X_WIDTH-1:0] x,
  input  logic [SPIXEL_Y_WIDTH-1:0] y,
  input  logic                      ireq,
  output logic                      obusy,
  output logic [VGA_ADDR_WIDTH-1:0] oaddr,
  output logic                      ordreq,
  input  logic [COLOR_ID_WIDTH-1:0] idata,
  output logic [COLOR_ID_WIDTH-1:0] odata,
  output logic                      odone,
  output logic                      omismatch
);

  localparam int AW = VGA_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state, state_nxt;
  logic                  accept;
  logic                  addr_last;
  logic                  first_ret;
  logic                  ret_vld, ret_last;
  logic [RD_LATENCY-1:0] vld_sr, last_sr;
  logic [AW-1:0]         start_addr, addr_next;

  assign accept     = (state == IDLE) && ireq && !odone;
  assign start_addr = AW'(y) * AW'(SPX_H) * AW'(H_RES) + AW'(x) * AW'(SPX_W);
  assign ret_vld    = vld_sr[RD_LATENCY-1];
  assign ret_last   = last_sr[RD_LATENCY-1];

`ifdef READ_SPIXEL_VERIFY_EN
  logic [SPIXEL_X_WIDTH-1:0] x_q;
  logic [SPIXEL_Y_WIDTH-1:0] y_q;
  logic [AW-1:0]             px, py, tlx_q, brx_q, bry_q;
  logic                      first_pend, mis_q;

  assign tlx_q     = AW'(x_q) * AW'(SPX_W);
  assign brx_q     = tlx_q + AW'(SPX_W - 1);
  assign bry_q     = AW'(y_q) * AW'(SPX_H) + AW'(SPX_H - 1);
  assign addr_last = (px == brx_q) && (py == bry_q);
  // Wrapping to the next row jumps over the rest of the frame line.
  assign addr_next = (px == brx_q) ? oaddr + AW'(H_RES - SPX_W + 1) : oaddr + AW'(1);
  assign first_ret = first_pend;
  assign omismatch = mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      px  <= '0;
      py  <= '0;
    end else if (accept) begin
      x_q <= x;
      y_q <= y;
      px  <= AW'(x) * AW'(SPX_W);
      py  <= AW'(y) * AW'(SPX_H);
    end else if (state == ISSUE && !addr_last) begin
      if (px == brx_q) begin
        px <= tlx_q;
        py <= py + AW'(1);
      end else begin
        px <= px + AW'(1);
      end
    end
  end

  // The first returned pixel becomes odata; every later one is compared against it.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_pend <= 1'b0;
      mis_q      <= 1'b0;
    end else if (accept) begin
      first_pend <= 1'b1;
      mis_q      <= 1'b0;
    end else if (ret_vld) begin
      if (first_pend) first_pend <= 1'b0;
      else if (idata != odata) mis_q <= 1'b1;
    end
  end
`else
  assign addr_last = 1'b1;
  assign addr_next = oaddr;
  assign first_ret = 1'b1;
  assign omismatch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (addr_last) state_nxt = DRAIN;
      DRAIN:   if (ret_vld && ret_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ordreq = (state == ISSUE);
    obusy  = (state != IDLE) || odone;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= ordreq;
      last_sr[0] <= ordreq && addr_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oaddr <= '0;
      odata <= '0;
      odone <= 1'b0;
    end else begin
      if (accept) oaddr <= start_addr;
      else if (state == ISSUE && !addr_last) oaddr <= addr_next;
      if (ret_vld && first_ret) odata <= idata;
      odone <= (state == DRAIN) && ret_vld && ret_last;
    end
  end

endmodule
